ppu_in_arbiter: RTL
===================

Name: ppu_in_arbiter

Overview:
- Shares one PPU input port between NUM_SRC flow-classification output channels.
- Uses the same req/ack/wr packet handshake on both sides.
- Sits between flow_classification and the ppu in np_core.
- Grants whole packets round-robin, holds the grant until the source drops req, and forwards data through one register stage.

Parameters:
- NUM_SRC, 4: number of requesting channels (2..8).
- DATA_WIDTH, 64: packet word width.
- ROUTE_WIDTH, 16: pkt_route width.
- SRC_BITS, 2: clog2(NUM_SRC), at least 1.

Ports:
- clk  in  1  core clock.
- reset  in  1  synchronous, active-low reset.
- in_data  in  NUM_SRC*DATA_WIDTH  packed source data; source i occupies [i*DATA_WIDTH +: DATA_WIDTH].
- in_pkt_route  in  NUM_SRC*ROUTE_WIDTH  packed per-source route tags.
- in_wr  in  NUM_SRC  per-source word valid.
- in_req  in  NUM_SRC  per-source packet request, held for the whole packet.
- in_ack  out  NUM_SRC  per-source grant (one-hot or zero).
- out_data  out  DATA_WIDTH  to PPU in_dataN.
- out_pkt_route  out  ROUTE_WIDTH  to PPU in_pkt_routeN.
- out_wr  out  1  word valid to PPU.
- out_req  out  1  request to PPU.
- out_ack  in  1  PPU acceptance.
- grant_src  out  SRC_BITS  index of the current owner (debug).

Behaviour:
- Reset: reset==0 at a rising clk edge forces the following, regardless of state, including mid-packet:
  - in_ack=0, out_req=0, out_wr=0, out_data=0, out_pkt_route=0, grant_src=0.
  - Round-robin pointer rr=0; FSM=IDLE.
- FSM states IDLE, REQ, XFER, REL.
  - IDLE:
    - If any in_req is set, choose the first requesting index at or after rr, modulo NUM_SRC. Latch it as owner and into grant_src.
    - Assert out_req next cycle; go to REQ.
  - REQ:
    - out_req=1. Wait for out_ack=1.
    - Then assert in_ack[owner] on the next cycle and go to XFER.
    - If in_req[owner] drops before out_ack, go to REL without acking.
  - XFER:
    - in_ack[owner]=1 and out_req=1.
    - Each cycle: out_wr<=in_wr[owner], out_data<=in_data slice, out_pkt_route<=in_pkt_route slice.
    - Latency is exactly 1 cycle from input to output.
    - Words from non-owners are ignored and never appear on the output.
    - When in_req[owner]=0: drop in_ack and out_req next cycle, set rr<=owner+1 (wrapping at NUM_SRC), go to REL.
    - A final word sampled in that same cycle is still forwarded.
  - REL:
    - out_req=0, in_ack=0. Wait for out_ack=0, then go to IDLE.
    - The next grant may start from IDLE the cycle after that.
- Non-owner requesters stay pending with in_ack=0 and are never dropped. Worst-case wait is NUM_SRC-1 packets.
- out_ack seen in IDLE or REL is ignored until it clears.
- out_data and out_pkt_route hold their last value when out_wr=0.
- An owner index outside NUM_SRC is impossible, because the pointer wraps modulo NUM_SRC.

Optional Feature:
- PPU_ARB_STATS_EN defined:
  - Adds output pkt_count of width NUM_SRC*32, one counter per source.
  - Adds output word_count, 32 bits.
  - pkt_count[i] increments on each XFER entry for source i.
  - word_count increments per forwarded out_wr.
  - Both wrap at 2^32 and clear on reset.
- Not defined: no counters, no ports; all other behaviour is identical.

Decomposition:
- Package ppu_arb_pkg:
  - FSM state encoding (IDLE=0, REQ=1, XFER=2, REL=3).
  - Default widths.
  - function rr_pick(req, rr), returning the next index.
- Natural sub-module: rr_priority_pick. It is a combinational round-robin picker with inputs req and rr, and outputs valid and idx. It is reused by the output arbiter.

Test Plan:
- Single source:
  - Stimulus: source 1 requests, out_ack returns after 3 cycles, 8 words streamed.
  - Required: in_ack[1] rises 1 cycle after out_ack; out_wr shows the 8 words, 1-cycle delayed and in order; out_req falls 1 cycle after in_req[1] falls.
- Round-robin fairness:
  - Stimulus: sources 0, 2 and 3 request continuously.
  - Required: grant order is 0, 2, 3, 0 over successive packets; no source is granted twice in a row while others wait.
- Isolation:
  - Stimulus: non-owner source 3 pulses in_wr with data 0xDEAD while source 0 is owner.
  - Required: out_data never equals 0xDEAD; only source 0 words appear.
- Early abort:
  - Stimulus: source 2 drops in_req during REQ, before out_ack.
  - Required: in_ack[2] is never asserted; FSM passes REL then IDLE; rr stays unchanged.
- Reset mid-packet:
  - Stimulus: reset=0 during word 4 of 10.
  - Required: next cycle all outputs are 0 and FSM=IDLE; after reset=1 with the source still requesting, a fresh grant starts from rr=0.
- PPU_ARB_STATS_EN:
  - Stimulus: 3 packets from source 1 of 5 words each.
  - Required: pkt_count[1]=3 and word_count=15.

Source files
------------

// File: rtl/ppu_arb_pkg.sv
// ppu_arb_pkg: shared FSM encoding, default widths and round-robin pick helper for the PPU input arbiter
package ppu_arb_pkg;
    localparam int NUM_SRC_D     = 4;
    localparam int DATA_WIDTH_D  = 64;
    localparam int ROUTE_WIDTH_D = 16;
    localparam int SRC_BITS_D    = 2;
    localparam int MAX_SRC       = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        XFER = 2'd2,
        REL  = 2'd3
    } arb_state_t;

    // Returns {valid, idx}: first set bit of req at or after rr, modulo n.
    // Scanning from the far end lets the nearest candidate overwrite the result.
    function automatic logic [3:0] rr_pick(input logic [7:0] req, input logic [2:0] rr, input int n);
        logic [3:0] r;
        int j;
        r = '0;
        for (int k = MAX_SRC - 1; k >= 0; k--) begin
            j = (int'(rr) + k) % n;
            if (k < n && req[j]) r = {1'b1, 3'(j)};
        end
        return r;
    endfunction
endpackage

// File: rtl/rr_priority_pick.sv
// rr_priority_pick: combinational round-robin picker
//   req   : per-source request vector
//   rr    : index with highest priority this round
//   valid : some request is set
//   idx   : first requesting index at or after rr, modulo N
module rr_priority_pick import ppu_arb_pkg::*; #(
    parameter int N = NUM_SRC_D,
    parameter int W = SRC_BITS_D
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] rr,
    output logic         valid,
    output logic [W-1:0] idx
);
    logic [3:0] w_pick;

    assign w_pick = rr_pick(8'(req), 3'(rr), N);
    assign valid  = w_pick[3];
    assign idx    = W'(w_pick[2:0]);
endmodule

// File: rtl/ppu_in_arbiter.sv
// ppu_in_arbiter: shares one PPU input port between NUM_SRC classifier channels, whole packets round-robin
//   clk, reset            : core clock, synchronous active-low reset
//   in_data/in_pkt_route  : packed per-source word and route tag
//   in_wr, in_req, in_ack : per-source word valid, packet request, grant
//   out_*                 : registered word/route/valid/request towards the PPU, out_ack from the PPU
//   grant_src             : current owner index
//   PPU_ARB_STATS_EN      : adds pkt_count (32 bits per source) and word_count
module ppu_in_arbiter import ppu_arb_pkg::*; #(
    parameter int NUM_SRC     = NUM_SRC_D,
    parameter int DATA_WIDTH  = DATA_WIDTH_D,
    parameter int ROUTE_WIDTH = ROUTE_WIDTH_D,
    parameter int SRC_BITS    = SRC_BITS_D
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [NUM_SRC*DATA_WIDTH-1:0]  in_data,
    input  logic [NUM_SRC*ROUTE_WIDTH-1:0] in_pkt_route,
    input  logic [NUM_SRC-1:0]             in_wr,
    input  logic [NUM_SRC-1:0]             in_req,
    output logic [NUM_SRC-1:0]             in_ack,
    output logic [DATA_WIDTH-1:0]          out_data,
    output logic [ROUTE_WIDTH-1:0]         out_pkt_route,
    output logic                           out_wr,
    output logic                           out_req,
    input  logic                           out_ack,
    output logic [SRC_BITS-1:0]            grant_src
`ifdef PPU_ARB_STATS_EN
    ,
    output logic [NUM_SRC*32-1:0]          pkt_count,
    output logic [31:0]                    word_count
`endif
);
    arb_state_t               r_state;
    logic [SRC_BITS-1:0]      r_owner;
    logic [SRC_BITS-1:0]      r_rr;
    logic [NUM_SRC-1:0]       r_in_ack;
    logic                     r_out_req;
    logic                     r_out_wr;
    logic [DATA_WIDTH-1:0]    r_out_data;
    logic [ROUTE_WIDTH-1:0]   r_out_route;

    logic                     w_valid;
    logic [SRC_BITS-1:0]      w_idx;
    logic                     w_own_req;
    logic                     w_own_wr;
    logic [DATA_WIDTH-1:0]    w_own_data;
    logic [ROUTE_WIDTH-1:0]   w_own_route;
    logic [SRC_BITS-1:0]      w_rr_next;
    logic                     w_xfer_start;

    rr_priority_pick #(.N(NUM_SRC), .W(SRC_BITS)) u_pick (
        .req   (in_req),
        .rr    (r_rr),
        .valid (w_valid),
        .idx   (w_idx)
    );

    assign w_own_req    = in_req[r_owner];
    assign w_own_wr     = in_wr[r_owner];
    assign w_own_data   = in_data[r_owner*DATA_WIDTH +: DATA_WIDTH];
    assign w_own_route  = in_pkt_route[r_owner*ROUTE_WIDTH +: ROUTE_WIDTH];
    assign w_rr_next    = (int'(r_owner) == NUM_SRC - 1) ? '0 : r_owner + 1'b1;
    // Abort takes precedence over a simultaneous out_ack: the owner is gone.
    assign w_xfer_start = (r_state == REQ) && w_own_req && out_ack;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state     <= IDLE;
            r_owner     <= '0;
            r_rr        <= '0;
            r_in_ack    <= '0;
            r_out_req   <= 1'b0;
            r_out_wr    <= 1'b0;
            r_out_data  <= '0;
            r_out_route <= '0;
        end else begin
            r_out_wr <= 1'b0;
            case (r_state)
                IDLE: if (w_valid) begin
                    r_owner   <= w_idx;
                    r_out_req <= 1'b1;
                    r_state   <= REQ;
                end
                REQ: if (!w_own_req) begin
                    r_out_req <= 1'b0;
                    r_state   <= REL;
                end else if (out_ack) begin
                    r_in_ack <= NUM_SRC'(1) << r_owner;
                    r_state  <= XFER;
                end
                XFER: begin
                    // The word sampled alongside the req drop is still forwarded.
                    r_out_wr <= w_own_wr;
                    if (w_own_wr) begin
                        r_out_data  <= w_own_data;
                        r_out_route <= w_own_route;
                    end
                    if (!w_own_req) begin
                        r_in_ack  <= '0;
                        r_out_req <= 1'b0;
                        r_rr      <= w_rr_next;
                        r_state   <= REL;
                    end
                end
                REL: if (!out_ack) r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

    assign in_ack        = r_in_ack;
    assign out_req       = r_out_req;
    assign out_wr        = r_out_wr;
    assign out_data      = r_out_data;
    assign out_pkt_route = r_out_route;
    assign grant_src     = r_owner;

`ifdef PPU_ARB_STATS_EN
    logic [31:0] r_pkt_cnt [NUM_SRC];
    logic [31:0] r_word_cnt;

    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < NUM_SRC; i++) r_pkt_cnt[i] <= '0;
            r_word_cnt <= '0;
        end else begin
            if (w_xfer_start) r_pkt_cnt[r_owner] <= r_pkt_cnt[r_owner] + 1'b1;
            if (r_state == XFER && w_own_wr) r_word_cnt <= r_word_cnt + 1'b1;
        end
    end

    for (genvar g = 0; g < NUM_SRC; g++) begin : g_cnt
        assign pkt_count[g*32 +: 32] = r_pkt_cnt[g];
    end
    assign word_count = r_word_cnt;
`endif
endmodule
